// File: rtl/mask_rng.sv
// mask_rng: xorshift64 randomness source for the masked arithmetic datapath.
// Loads and sanitises seeds, runs a WARMUP-step warm-up after each seed, then
// hands out one RADIX-bit mask word per rnd_valid/rnd_ready handshake.
// Optional health monitor enabled by defining MASK_RNG_HEALTH_EN: it adds the
// FAULT state and the sticky fault output.
module mask_rng #(
    parameter int unsigned      RADIX        = 64,
    parameter logic [RADIX-1:0] SEED_DEFAULT = 64'h1,
    parameter int unsigned      WARMUP       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             seed_valid,
    input  logic [RADIX-1:0] seed,
    output logic             seed_ready,
    output logic             rnd_valid,
    output logic [RADIX-1:0] rnd,
    input  logic             rnd_ready
`ifdef MASK_RNG_HEALTH_EN
    ,
    output logic             fault
`endif
);

`ifdef MASK_RNG_HEALTH_EN
    typedef enum logic [1:0] {
        ST_UNSEEDED = 2'd0,
        ST_WARM     = 2'd1,
        ST_RUN      = 2'd2,
        ST_FAULT    = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_UNSEEDED = 2'd0,
        ST_WARM     = 2'd1,
        ST_RUN      = 2'd2
    } state_t;
`endif

    localparam logic [7:0] WARM_LAST = 8'(WARMUP - 1);

    state_t           state;
    state_t           state_nxt;
    logic [RADIX-1:0] s;
    logic [RADIX-1:0] s_nxt;
    logic [RADIX-1:0] f_s;
    logic [7:0]       cnt;
    logic [7:0]       cnt_nxt;
    logic             seed_fire;

    // One xorshift64 step with the 21/35/4 shift triple; shifts are logical
    // and truncate to the register width.
    function automatic logic [RADIX-1:0] xorshift(input logic [RADIX-1:0] v);
        logic [RADIX-1:0] y;
        logic [RADIX-1:0] z;
        y = v ^ (v << 21);
        z = y ^ (y >> 35);
        return z ^ (z << 4);
    endfunction

    // All outputs are decoded from registers so nothing combinational reaches
    // from the inputs to the outputs.
    always_comb begin
        f_s        = xorshift(s);
        rnd        = s;
        rnd_valid  = (state == ST_RUN);
`ifdef MASK_RNG_HEALTH_EN
        seed_ready = (state != ST_FAULT);
        fault      = (state == ST_FAULT);
`else
        seed_ready = 1'b1;
`endif
        seed_fire  = seed_valid & seed_ready;
    end

    // Next-state logic: a seed load beats everything else (including a
    // simultaneous rnd handshake, whose word still counts as delivered), and
    // a zero seed is replaced because zero is the xorshift fixed point.
    always_comb begin
        state_nxt = state;
        s_nxt     = s;
        cnt_nxt   = cnt;
        if (seed_fire) begin
            s_nxt     = (seed == '0) ? SEED_DEFAULT : seed;
            cnt_nxt   = 8'd0;
            state_nxt = ST_WARM;
        end else begin
            case (state)
                ST_WARM: begin
                    s_nxt   = f_s;
                    cnt_nxt = cnt + 8'd1;
                    if (cnt == WARM_LAST) begin
                        state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (rnd_ready) begin
                        s_nxt = f_s;
                    end
                end
                default: begin
                end
            endcase
        end
`ifdef MASK_RNG_HEALTH_EN
        // A zero or self-mapping state can only come from corruption, so it
        // freezes everything in FAULT until reset.
        if (((state == ST_WARM) || (state == ST_RUN)) &&
            ((s == '0) || (f_s == s))) begin
            state_nxt = ST_FAULT;
            s_nxt     = s;
            cnt_nxt   = cnt;
        end
`endif
    end

    // State, generator register and warm-up counter with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_UNSEEDED;
            s     <= '0;
            cnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            s     <= s_nxt;
            cnt   <= cnt_nxt;
        end
    end

endmodule
